// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// A port that keeps winning yields after MAX_BURST grants if the other port is waiting.
module dmem_arbiter #(
  parameter int unsigned ADD_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADD_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADD_WIDTH-1:0]  addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADD_WIDTH-1:0]  mem_a,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

  logic                  last_q, last_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  keep_last;

  // The current holder keeps the memory only while its burst is live and unexhausted.
  assign keep_last = (cnt_q != '0) && (cnt_q < MaxCnt);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (req0 && req1) begin
        if (keep_last) begin
          gnt0 = ~last_q;
          gnt1 = last_q;
        end else begin
          gnt0 = last_q;
          gnt1 = ~last_q;
        end
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    mem_a  = '0;
    mem_we = 1'b0;
    mem_wd = '0;
    if (gnt0) begin
      mem_a  = addr0;
      mem_we = we0;
      mem_wd = wdata0;
    end else if (gnt1) begin
      mem_a  = addr1;
      mem_we = we1;
      mem_wd = wdata1;
    end
  end

  always_comb begin
    last_d = last_q;
    cnt_d  = '0;
    if (gnt0 || gnt1) begin
      last_d = gnt1;
      if ((gnt1 == last_q) && (cnt_q != '0)) begin
        cnt_d = (cnt_q >= MaxCnt) ? MaxCnt : cnt_q + CntW'(1);
      end else begin
        cnt_d = CntW'(1);
      end
    end
    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
    rdata0_d  = rvalid0_d ? mem_rd : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_rd : rdata1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= 1'b1;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule
